// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning path:
//   - rpt_state_e : auto-repeat FSM state encoding
//   - DEFAULT_*   : timing constants expressed in 25 MHz clock cycles
//   - cnt_width   : bits needed to hold a count from 0 up to max_val
//   - max_int     : larger of two integers (used to size the shared repeat counter)
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 25 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_REPEAT_DELAY    = 12500000;
  localparam int DEFAULT_REPEAT_PERIOD   = 2500000;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One button: two-flop synchroniser, stable-count debouncer and auto-repeat
// FSM. All outputs are registered and change on the same edge as level_o.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset, clears every flop
//   raw_i     : raw asynchronous button level (active high)
//   level_o   : debounced level
//   press_o   : one-cycle strobe on debounced rise
//   release_o : one-cycle strobe on debounced fall
//   repeat_o  : strobe at press, then at each auto-repeat point while held
// ---------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             meta_q;
  logic             sync_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  logic rise, fall;

  // Debounce: count consecutive cycles where the synchronised input disagrees
  // with the accepted level; any agreement restarts the count.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sync_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = sync_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Edge events are taken from the level update itself so the strobes land
  // on exactly the edge where level_q changes.
  assign rise      = level_d & ~level_q;
  assign fall      = ~level_d & level_q;
  assign press_d   = rise;
  assign release_d = fall;

  // Auto-repeat FSM. A fall always wins over a terminal count in the same
  // cycle, so no repeat strobe accompanies a release.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (rise) begin
          state_d  = DELAY;
          repeat_d = 1'b1;
        end
      end
      DELAY: begin
        if (fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == DELAY_LAST) begin
          state_d   = REPEAT;
          rpt_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          rpt_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Conditions NUM_BTNS raw push-button inputs for the game core: each bit is
// synchronised, debounced and given press/release/auto-repeat strobes by an
// independent btn_channel.
// Ports:
//   CLK_25MHZ   : system clock
//   RESET_N     : asynchronous active-low reset
//   BTN_RAW     : raw asynchronous button levels (active high)
//   BTN_LEVEL   : debounced levels
//   BTN_PRESS   : one-cycle strobe per debounced rise
//   BTN_RELEASE : one-cycle strobe per debounced fall
//   BTN_REPEAT  : strobe at press and at each auto-repeat point while held
// ---------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                CLK_25MHZ,
  input  logic                RESET_N,
  input  logic [NUM_BTNS-1:0] BTN_RAW,
  output logic [NUM_BTNS-1:0] BTN_LEVEL,
  output logic [NUM_BTNS-1:0] BTN_PRESS,
  output logic [NUM_BTNS-1:0] BTN_RELEASE,
  output logic [NUM_BTNS-1:0] BTN_REPEAT
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
        .clk      (CLK_25MHZ),
        .rst_n    (RESET_N),
        .raw_i    (BTN_RAW[gi]),
        .level_o  (BTN_LEVEL[gi]),
        .press_o  (BTN_PRESS[gi]),
        .release_o(BTN_RELEASE[gi]),
        .repeat_o (BTN_REPEAT[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. "Cycle c" means the outputs sampled 1 ns after the c-th
// rising edge following the edge at which the stimulus changed (cycle 0).
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] raw;
  logic [1:0] lvl, prs, rel, rpt;

  int total = 0;
  int bad   = 0;

  logic [1:0] e_lvl, e_prs, e_rel, e_rpt;

  always #20 clk = ~clk;

  btn_conditioner #(
    .NUM_BTNS       (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLK_25MHZ  (clk),
    .RESET_N    (rst_n),
    .BTN_RAW    (raw),
    .BTN_LEVEL  (lvl),
    .BTN_PRESS  (prs),
    .BTN_RELEASE(rel),
    .BTN_REPEAT (rpt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] x_lvl, input logic [1:0] x_prs,
                         input logic [1:0] x_rel, input logic [1:0] x_rpt);
    chk({tag, ".level"},   lvl, x_lvl);
    chk({tag, ".press"},   prs, x_prs);
    chk({tag, ".release"}, rel, x_rel);
    chk({tag, ".repeat"},  rpt, x_rpt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    raw   = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    raw   = 2'b00;
    tick(); tick(); tick();
    chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 2'b00, 2'b00, 2'b00, 2'b00);

    // ---------------- clean press, release at cycle 20 ----------------
    // The repeat at 25 still fires: the level is high until edge 26.
    tick();
    raw = 2'b01;
    for (int c = 1; c <= 32; c++) begin
      tick();
      e_lvl = {1'b0, (c >= 6 && c <= 25)};
      e_prs = {1'b0, (c == 6)};
      e_rel = {1'b0, (c == 26)};
      e_rpt = {1'b0, (c == 6 || c == 16 || c == 19 || c == 22 || c == 25)};
      chk_all($sformatf("press_rel c%0d", c), e_lvl, e_prs, e_rel, e_rpt);
      if (c == 20) raw = 2'b00;
    end

    // ---------------- release coincides with repeat point 28 ----------------
    do_reset();
    tick();
    raw = 2'b01;
    for (int c = 1; c <= 34; c++) begin
      tick();
      e_lvl = {1'b0, (c >= 6 && c <= 27)};
      e_prs = {1'b0, (c == 6)};
      e_rel = {1'b0, (c == 28)};
      e_rpt = {1'b0, (c == 6 || c == 16 || c == 19 || c == 22 || c == 25)};
      chk_all($sformatf("coincide c%0d", c), e_lvl, e_prs, e_rel, e_rpt);
      if (c == 22) raw = 2'b00;
    end

    // ---------------- bounce rejection ----------------
    do_reset();
    tick();
    raw = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_all($sformatf("bounce c%0d", c), 2'b00, 2'b00, 2'b00, 2'b00);
      if (c == 2) raw = 2'b00;
      if (c == 3) raw = 2'b01;
      if (c == 6) raw = 2'b00;
    end

    // ---------------- independent channels ----------------
    do_reset();
    tick();
    raw = 2'b11;
    for (int c = 1; c <= 24; c++) begin
      tick();
      e_lvl = {(c >= 6 && c <= 13), (c >= 6)};
      e_prs = {(c == 6), (c == 6)};
      e_rel = {(c == 14), 1'b0};
      e_rpt = {(c == 6), (c == 6 || c == 16 || c == 19 || c == 22)};
      chk_all($sformatf("indep c%0d", c), e_lvl, e_prs, e_rel, e_rpt);
      if (c == 8) raw = 2'b01;
    end

    // ---------------- reset mid-repeat ----------------
    do_reset();
    tick();
    raw = 2'b01;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e_lvl = {1'b0, (c >= 6)};
      e_prs = {1'b0, (c == 6)};
      e_rpt = {1'b0, (c == 6)};
      chk_all($sformatf("pre_rst c%0d", c), e_lvl, e_prs, 2'b00, e_rpt);
    end
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst_immediate", 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("mid_rst_hold1", 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("mid_rst_hold2", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e_lvl = {1'b0, (c >= 6)};
      e_prs = {1'b0, (c == 6)};
      e_rpt = {1'b0, (c == 6)};
      chk_all($sformatf("after_rst c%0d", c), e_lvl, e_prs, 2'b00, e_rpt);
    end

    // ---------------- held through reset ----------------
    rst_n = 1'b0;
    raw   = 2'b00;
    tick();
    raw = 2'b01;
    tick();
    tick();
    chk_all("held_in_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e_lvl = {1'b0, (c >= 6)};
      e_prs = {1'b0, (c == 6)};
      e_rpt = {1'b0, (c == 6)};
      chk_all($sformatf("held c%0d", c), e_lvl, e_prs, 2'b00, e_rpt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
